uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver for the 8N1 UART link: 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity, line idles high.
- Pairs with the existing 9600-baud transmitter on the same link.
- Oversamples the line 16x and samples each bit at mid-bit.
- Delivers each received byte with a one-cycle valid strobe to the command/control logic, and flags frames with a bad stop bit.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate in Hz.
- OVERSAMPLE, 16, ticks per bit. Must be even and ≥ 8.
- Derived localparam DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncating division. At defaults DIV = 651.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line input, idle high.
- data  out  8  last good byte; held until the next good byte.
- valid  out  1  one-cycle pulse: data updated this cycle.
- frame_err  out  1  one-cycle pulse: stop bit sampled low; data not updated.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: data=0x00, valid=0, frame_err=0, busy=0, state=IDLE. Synchronizer flops and the edge-detect register reset to 1. Tick and bit counters reset to 0.
- A reset asserted mid-frame aborts the frame with no valid and no frame_err pulse. The next start is recognised only after a new falling edge.
- Synchronizer: 2-flop chain on rx gives rx_s. rx_prev holds rx_s delayed one cycle. Falling edge = rx_prev & ~rx_s.
- Tick generator:
  - Counter 0..DIV-1, producing a 1-cycle tick at wrap.
  - Held at 0 in IDLE.
  - Cleared on the start edge, so the first tick comes DIV cycles after the edge.
- Sample counter s (0..OVERSAMPLE-1) advances on each tick. Bit counter n (0..7).
- State machine:
  - IDLE: on a falling edge, go to START with s=0, n=0. Otherwise stay.
  - START:
    - When a tick arrives with s = OVERSAMPLE/2-1 (mid start bit), sample rx_s.
    - If 0: go to DATA with s=0.
    - If 1: false start (glitch), return to IDLE with no pulses.
  - DATA:
    - When a tick arrives with s = OVERSAMPLE-1, shift: shreg <= {rx_s, shreg[7:1]}.
    - If n=7 go to STOP; else n <= n+1. s wraps to 0.
  - STOP: when a tick arrives with s = OVERSAMPLE-1, sample rx_s.
    - 1: data <= shreg and valid=1 on the next cycle.
    - 0: frame_err=1 on the next cycle.
    - Either way, return to IDLE.
- Outcome: exactly one of valid or frame_err pulses per completed frame; never both, never more than one cycle.
- Break condition (line held low): after frame_err, IDLE waits for a true falling edge. A line that stays low generates no further frames.
- Back-to-back frames: the return to IDLE happens mid stop bit, so the next start edge is caught with no gap needed.
- Latency: valid rises about 9.5 bit times + 3 clk after the line's start edge (synchronizer 2 clk, registered output 1 clk).
- No backpressure: the consumer must take data on the valid cycle. Data holds until overwritten by the next good byte.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, STOP.
  - UART_DATA_BITS=8.
  - Default OVERSAMPLE=16.
  - A shared function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE.
- Sub-module uart_baud_tick: parameterised by DIV, with clk, rst, clear and tick ports. Reusable by a future oversampled transmitter.
- Synchronizer, edge detect, FSM and shift register stay in uart_rx.

Test Plan:
Bench parameters: CLK_FREQ=6_400_000, BAUD=100_000, giving DIV=4 and 64 clk per bit.
1. Drive a frame for 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) -> data=0xA5 and one valid pulse about 611 clk after the start edge; frame_err stays 0.
2. Send 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses, data=0x00 then 0xFF, busy low for only a few cycles between frames.
3. Send 0x3C with the stop bit driven 0 -> frame_err pulses once, no valid, data keeps its prior value. Hold rx low for 3 bit times, then idle -> no further pulses.
4. Glitch rx low for 20 clk (less than half a bit) -> returns to IDLE, no pulses. A following 0x5A frame is received correctly.
5. Assert rst for 1 cycle mid-frame after bit 3 of 0x81, then send 0x81 cleanly -> no pulse for the aborted frame, then data=0x81 with a single valid.
6. Send 0x55 with the bit period stretched 3% (66 clk/bit) -> data=0x55 and valid, confirming mid-bit sampling tolerance.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and baud divider helper
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Clock cycles per oversample tick; truncates, so the tick runs slightly fast.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one-cycle tick every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    // Held at zero while cleared, so the first tick lands DIV cycles after release.
    assign tick = ~clear & (r_count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16x oversampled, mid-bit sampling
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int            DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int            SW     = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam int            NW     = $clog2(UART_DATA_BITS);
    localparam logic [NW-1:0] N_LAST = NW'(UART_DATA_BITS - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_rx_prev;
    uart_state_t r_state;
    logic [SW-1:0] r_s;
    logic [NW-1:0] r_n;
    logic [7:0]  r_shreg;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_frame_err;

    uart_state_t   w_state_nx;
    logic [SW-1:0] w_s_nx;
    logic [NW-1:0] w_n_nx;
    logic [7:0]    w_shreg_nx;
    logic [7:0]    w_data_nx;
    logic          w_valid_nx;
    logic          w_frame_err_nx;
    logic          w_fall;
    logic          w_tick;

    // Sync flops reset high so a line idling high never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall = r_rx_prev & ~r_sync2;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (r_state == IDLE),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_s         <= w_s_nx;
            r_n         <= w_n_nx;
            r_shreg     <= w_shreg_nx;
            r_data      <= w_data_nx;
            r_valid     <= w_valid_nx;
            r_frame_err <= w_frame_err_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_s_nx         = r_s;
        w_n_nx         = r_n;
        w_shreg_nx     = r_shreg;
        w_data_nx      = r_data;
        w_valid_nx     = 1'b0;
        w_frame_err_nx = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nx = START;
                    w_s_nx     = '0;
                    w_n_nx     = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == S_MID) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        w_state_nx = r_sync2 ? IDLE : DATA;
                        w_s_nx     = '0;
                    end else begin
                        w_s_nx = r_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == S_LAST) begin
                        w_shreg_nx = {r_sync2, r_shreg[7:1]};
                        w_s_nx     = '0;
                        if (r_n == N_LAST) begin
                            w_state_nx = STOP;
                        end else begin
                            w_n_nx = r_n + 1'b1;
                        end
                    end else begin
                        w_s_nx = r_s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s == S_LAST) begin
                        // Leaving mid stop bit lets a back-to-back start edge be caught.
                        w_state_nx = IDLE;
                        if (r_sync2) begin
                            w_data_nx  = r_shreg;
                            w_valid_nx = 1'b1;
                        end else begin
                            w_frame_err_nx = 1'b1;
                        end
                    end else begin
                        w_s_nx = r_s + 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at 64 clk per bit
module tb_uart_rx;

    localparam int BIT     = 64;
    localparam int EXP_LAT = (19 * BIT) / 2 + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (6_400_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: counts pulses and captures every delivered byte.
    int         n_valid   = 0;
    int         n_ferr    = 0;
    int         n_both    = 0;
    int         n_long    = 0;
    int         valid_cyc = 0;
    int         low_run   = 0;
    int         gap_run   = 0;
    logic       p_valid   = 1'b0;
    logic       p_ferr    = 1'b0;
    logic       p_busy    = 1'b0;
    logic [7:0] q_got[$];

    always @(negedge clk) begin
        if (valid) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
            q_got.push_back(data);
        end
        if (frame_err) n_ferr = n_ferr + 1;
        if (valid && frame_err) n_both = n_both + 1;
        if ((valid && p_valid) || (frame_err && p_ferr)) n_long = n_long + 1;
        if (!busy) begin
            low_run = low_run + 1;
        end else begin
            if (!p_busy) gap_run = low_run;
            low_run = 0;
        end
        p_valid = valid;
        p_ferr  = frame_err;
        p_busy  = busy;
    end

    int         edge_cyc;
    logic [7:0] last_good = 8'h00;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
        rx = 1'b0;
        edge_cyc = cyc;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (per) @(negedge clk);
        end
        rx = stop;
        repeat (per) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        idle(5);
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        idle(3 * BIT);
    endtask

    task automatic test_basic;
        int v0, f0, lat;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hA5, 1'b1, BIT);
        idle(2 * BIT);
        last_good = 8'hA5;
        lat = valid_cyc - edge_cyc;
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL basic_valid_count: got %0d want 1", n_valid - v0); end
        total++; if (n_ferr != f0) begin bad++; $display("FAIL basic_ferr_count: got %0d want 0", n_ferr - f0); end
        total++; if (data !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", data); end
        total++;
        if (lat < EXP_LAT - 4 || lat > EXP_LAT + 4) begin
            bad++; $display("FAIL basic_latency: got %0d want %0d +/-4", lat, EXP_LAT);
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = n_valid;
        send_frame(8'h00, 1'b1, BIT);
        send_frame(8'hFF, 1'b1, BIT);
        idle(2 * BIT);
        last_good = 8'hFF;
        total++;
        if (n_valid - v0 != 2) begin
            bad++; $display("FAIL b2b_valid_count: got %0d want 2", n_valid - v0);
        end else begin
            total++; if (q_got[v0] !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h want 00", q_got[v0]); end
            total++; if (q_got[v0+1] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h want ff", q_got[v0+1]); end
        end
        total++;
        if (gap_run < 1 || gap_run >= BIT) begin
            bad++; $display("FAIL b2b_busy_gap: got %0d want 1..%0d", gap_run, BIT - 1);
        end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, BIT);
        rx = 1'b0;
        total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); end
        total++; if (n_valid != v0) begin bad++; $display("FAIL ferr_no_valid: got %0d want 0", n_valid - v0); end
        total++; if (data !== last_good) begin bad++; $display("FAIL ferr_data_held: got %h want %h", data, last_good); end
        idle(3 * BIT);
        rx = 1'b1;
        idle(3 * BIT);
        total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL break_ferr_count: got %0d want 1", n_ferr - f0); end
        total++; if (n_valid != v0) begin bad++; $display("FAIL break_valid: got %0d want 0", n_valid - v0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_busy: got %b want 0", busy); end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(12 * BIT);
        total++;
        if (n_valid != v0 || n_ferr != f0) begin
            bad++; $display("FAIL glitch_pulses: got v=%0d f=%0d want 0 0", n_valid - v0, n_ferr - f0);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
        send_frame(8'h5A, 1'b1, BIT);
        idle(2 * BIT);
        last_good = 8'h5A;
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL glitch_next_count: got %0d want 1", n_valid - v0); end
        total++; if (data !== 8'h5A) begin bad++; $display("FAIL glitch_next_data: got %h want 5a", data); end
    endtask

    task automatic test_reset_abort;
        int         v0, f0;
        logic [7:0] b;
        b  = 8'h81;
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            idle(BIT);
        end
        rx = b[4];
        idle(BIT / 2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_mid: got %b want 1", busy); end
        rst = 1'b1;
        rx  = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(12 * BIT);
        last_good = 8'h00;
        total++;
        if (n_valid != v0 || n_ferr != f0) begin
            bad++; $display("FAIL abort_pulses: got v=%0d f=%0d want 0 0", n_valid - v0, n_ferr - f0);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (data !== last_good) begin bad++; $display("FAIL abort_data: got %h want %h", data, last_good); end
        send_frame(b, 1'b1, BIT);
        idle(2 * BIT);
        last_good = b;
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL abort_next_count: got %0d want 1", n_valid - v0); end
        total++; if (data !== 8'h81) begin bad++; $display("FAIL abort_next_data: got %h want 81", data); end
    endtask

    task automatic test_baud_tolerance;
        int v0;
        v0 = n_valid;
        send_frame(8'h55, 1'b1, 66);
        idle(2 * BIT);
        last_good = 8'h55;
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL slow_count: got %0d want 1", n_valid - v0); end
        total++; if (data !== 8'h55) begin bad++; $display("FAIL slow_data: got %h want 55", data); end
    endtask

    task automatic test_random;
        int         v0, f0;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        v0 = n_valid; f0 = n_ferr;
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, $urandom_range(63, 65));
            exp_q.push_back(b);
            idle($urandom_range(0, 40));
        end
        idle(2 * BIT);
        last_good = exp_q[exp_q.size() - 1];
        total++; if (n_ferr != f0) begin bad++; $display("FAIL rand_ferr: got %0d want 0", n_ferr - f0); end
        total++;
        if (n_valid - v0 != exp_q.size()) begin
            bad++; $display("FAIL rand_count: got %0d want %0d", n_valid - v0, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                total++;
                if (q_got[v0+k] !== exp_q[k]) begin
                    bad++; $display("FAIL rand_byte%0d: got %h want %h", k, q_got[v0+k], exp_q[k]);
                end
            end
        end
        total++; if (data !== last_good) begin bad++; $display("FAIL rand_data: got %h want %h", data, last_good); end
    endtask

    task automatic test_pulse_shape;
        total++; if (n_both != 0) begin bad++; $display("FAIL pulse_both: got %0d want 0", n_both); end
        total++; if (n_long != 0) begin bad++; $display("FAIL pulse_width: got %0d want 0", n_long); end
    endtask

    initial begin
        idle(1);
        test_reset;
        test_basic;
        test_back_to_back;
        test_frame_err;
        test_glitch;
        test_reset_abort;
        test_baud_tolerance;
        test_random;
        test_pulse_shape;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
